// File: rtl/store_trace_monitor.sv
// Store trace monitor: captures core data-memory stores into a show-ahead trace FIFO
// and classifies the run as pass/fail from the store stream.
module store_trace_monitor #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memWrite,
  input  logic [31:0]              dataAddress,
  input  logic [31:0]              storeData,
  output logic                     traceValid,
  input  logic                     traceReady,
  output logic [31:0]              traceAddress,
  output logic [31:0]              traceData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done,
  output logic                     pass,
  output logic                     fail
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  typedef enum logic [1:0] {StRun, StPass, StFail} state_e;

  state_e state_q, state_d;

  logic [63:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;

  logic push_req, push, pop, full;

  // Checker: only stores issued while running are judged; verdicts are terminal.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (memWrite) begin
          if (dataAddress == PASS_ADDR && storeData == PASS_DATA) begin
            state_d = StPass;
          end else if (dataAddress != SCRATCH_ADDR) begin
            state_d = StFail;
          end
        end
      end
      StPass:  state_d = StPass;
      StFail:  state_d = StFail;
      default: state_d = StFail;
    endcase
  end

  assign full     = (count_q == CntFull);
  assign pop      = traceValid & traceReady;
  assign push_req = memWrite & (state_q == StRun);
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign push     = push_req & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req & ~push);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {dataAddress, storeData};
      end
    end
  end

  assign traceValid   = (count_q != '0);
  assign traceAddress = mem_q[rd_ptr_q][63:32];
  assign traceData    = mem_q[rd_ptr_q][31:0];
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign done         = (state_q != StRun);
  assign pass         = (state_q == StPass);
  assign fail         = (state_q == StFail);

endmodule

// File: doc/store_trace_monitor.md
# store_trace_monitor

Synthesizable consumer of the single-cycle core's data-memory write port (memWrite, dataAddress, storeData). Every store issued while a program runs is captured into a small trace FIFO that a host or debug port drains over a valid/ready handshake. A three-state checker classifies the run as pass or fail from the store stream, so hardware and FPGA builds self-check without a simulator. Sits beside the data memory, tapping the same core outputs; never back-pressures the core.

## Interface
Parameters:
- DEPTH, 8: trace FIFO entries; power of two, ≥2.
- PASS_ADDR, 32'd100: store address that ends the run.
- PASS_DATA, 32'd25: data value at PASS_ADDR that signals success.
- SCRATCH_ADDR, 32'd96: the only other address a correct program may store to.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- memWrite  in  1  core store strobe, sampled on rising clk.
- dataAddress  in  32  core store address.
- storeData  in  32  core store data.
- traceValid  out  1  FIFO non-empty; head entry presented.
- traceReady  in  1  consumer accepts head when traceValid=1.
- traceAddress  out  32  head entry address.
- traceData  out  32  head entry data.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a store was dropped because the FIFO was full.
- done  out  1  checker left RUN.
- pass  out  1  checker in PASS.
- fail  out  1  checker in FAIL.

## Operation
- Checker FSM states RUN, PASS, FAIL; reset → RUN.
- RUN, memWrite=1: address==PASS_ADDR and data==PASS_DATA → PASS; else address!=SCRATCH_ADDR → FAIL (includes PASS_ADDR with wrong data); else remain RUN.
- RUN, memWrite=0: remain RUN.
- PASS and FAIL are terminal; held until reset.
- done = (state!=RUN); pass = (state==PASS); fail = (state==FAIL); all registered, decoded from state.
- Push: memWrite=1 while state==RUN pushes {dataAddress, storeData}, including the terminating store. Stores while done=1 are neither checked nor pushed.
- Pop: traceValid & traceReady at a rising edge removes the head.
- Full rule: push accepted if count<DEPTH, or count==DEPTH with a pop in the same cycle. Otherwise the store is dropped, overflow set, and the checker still evaluates it.
- Simultaneous push and pop: count unchanged; with count==0, traceValid=0, so no pop occurs and the push lands.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count tracked separately; full = (count==DEPTH).
- traceReady while traceValid=0 is ignored.
- X/Z on inputs while memWrite=0 has no effect.

## Timing
- Reset values: traceValid=0, count=0, overflow=0, done=0, pass=0, fail=0; traceAddress/traceData=0 (storage cleared).
- Show-ahead FIFO: the store sampled at edge N sets traceValid=1 and presents head data after edge N (latency 1); no combinational path from memWrite to outputs.
- Checker verdict visible after the edge that samples the deciding store (latency 1).
- Pop at edge N presents the next entry after edge N; traceValid falls after edge N if count was 1 and there was no push.
- Reset asserted mid-run or mid-drain clears FIFO, verdict and overflow asynchronously; the first edge after deassertion already samples memWrite.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset then stores (96,7),(96,9),(100,25) on consecutive cycles, traceReady=0 → pass=1, done=1, fail=0 one cycle after third store; count=3; drained order (96,7),(96,9),(100,25).
- Store (104,25) as first write → fail=1 next cycle; later (100,25) → fail stays 1, pass=0, count stays 1.
- Store (100,24) → fail=1 (wrong data at PASS_ADDR).
- DEPTH=8, traceReady=0, 10 stores to 96 with data 1..10 → count=8, overflow=1, done=0; drain yields data 1..8.
- Full FIFO, same cycle store (96,0xAA) and traceReady=1 → count stays 8, overflow stays 0, 0xAA last in drain; pointers wrap correctly over 3 full cycles of DEPTH.
- Reset pulled low for 3 ns mid-stream with count=5, fail=1 → all outputs 0 immediately, before the next clk edge; subsequent (100,25) → pass=1.
